// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_e;

    localparam int BCD_DIGIT_W   = 4;
    localparam int BCD_MAX_VAL   = 999;
    localparam int BCD_MAX_WIDTH = 10;

endpackage

// File: rtl/bcd_dabble_step.sv
// Double-dabble correction for one BCD nibble: values of 5 and above get +3.
module bcd_dabble_step
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] nib,
    output logic [BCD_DIGIT_W-1:0] adj
);

    // add-3 correction ahead of the left shift
    always_comb begin
        adj = nib;
        if (nib >= 4'd5) begin
            adj = nib + 4'd3;
        end else begin
            adj = nib;
        end
    end

endmodule

// File: rtl/bcd_converter.sv
// Iterative (one bit per clock) binary-to-BCD converter with registered digit outputs.
// Optional macro BCD_SATURATE_EN: inputs above 999 saturate to 9/9/9 and raise ovf.
module bcd_converter
    import bcd_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       bin,
    input  logic                   start,
    output logic [BCD_DIGIT_W-1:0] ones,
    output logic [BCD_DIGIT_W-1:0] tens,
    output logic [BCD_DIGIT_W-1:0] hundreds,
    output logic                   busy,
    output logic                   done,
    output logic                   ovf
);

    localparam int ACC_W = 4 * BCD_DIGIT_W;   // thousands, hundreds, tens, ones
    localparam int OUT_W = 3 * BCD_DIGIT_W;
    localparam int CAT_W = ACC_W + WIDTH;

    bcd_state_e             state_r;
    bcd_state_e             next_state_s;
    logic [WIDTH-1:0]       shift_r;
    logic [ACC_W-1:0]       acc_r;
    logic [3:0]             cnt_r;
    logic [ACC_W-1:0]       adj_s;
    logic [CAT_W-1:0]       cat_s;
    logic                   last_shift_s;
    logic [OUT_W-1:0]       res_digits_s;
    logic                   res_ovf_s;
    logic [BCD_DIGIT_W-1:0] ones_r;
    logic [BCD_DIGIT_W-1:0] tens_r;
    logic [BCD_DIGIT_W-1:0] hundreds_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   ovf_r;

    for (genvar g = 0; g < 4; g++) begin : g_step
        bcd_dabble_step u_step (
            .nib (acc_r[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .adj (adj_s[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // corrected accumulator and binary shifted left together as one word
    always_comb begin
        cat_s        = {adj_s, shift_r} << 1'b1;
        last_shift_s = (cnt_r == 4'(WIDTH - 1));
    end

`ifdef BCD_SATURATE_EN
    logic sat_r;

    // remember at acceptance whether the request is out of display range
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_r <= 1'b0;
        end else if ((state_r == IDLE) && start) begin
            sat_r <= (32'(bin) > 32'(BCD_MAX_VAL));
        end else begin
            sat_r <= sat_r;
        end
    end

    // final digits: saturated or the freshly shifted accumulator
    always_comb begin
        res_digits_s = cat_s[WIDTH +: OUT_W];
        res_ovf_s    = 1'b0;
        if (sat_r) begin
            res_digits_s = {4'd9, 4'd9, 4'd9};
            res_ovf_s    = 1'b1;
        end else begin
            res_digits_s = cat_s[WIDTH +: OUT_W];
            res_ovf_s    = 1'b0;
        end
    end
`else
    // final digits: thousands nibble is simply dropped
    always_comb begin
        res_digits_s = cat_s[WIDTH +: OUT_W];
        res_ovf_s    = 1'b0;
    end
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = SHIFT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_shift_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = SHIFT;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // conversion datapath: load on acceptance, one dabble step per SHIFT cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r <= '0;
            acc_r   <= '0;
            cnt_r   <= 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        shift_r <= bin;
                        acc_r   <= '0;
                        cnt_r   <= 4'd0;
                    end
                end
                SHIFT: begin
                    shift_r <= cat_s[WIDTH-1:0];
                    acc_r   <= cat_s[CAT_W-1:WIDTH];
                    cnt_r   <= cnt_r + 4'd1;
                end
                default: begin
                    shift_r <= shift_r;
                end
            endcase
        end
    end

    // registered outputs; digits and ovf move only on the final shift edge
    always_ff @(posedge clk) begin
        if (rst) begin
            ones_r     <= 4'd0;
            tens_r     <= 4'd0;
            hundreds_r <= 4'd0;
            ovf_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            busy_r <= (next_state_s != IDLE);
            done_r <= (next_state_s == DONE);
            if ((state_r == SHIFT) && last_shift_s) begin
                hundreds_r <= res_digits_s[2*BCD_DIGIT_W +: BCD_DIGIT_W];
                tens_r     <= res_digits_s[BCD_DIGIT_W +: BCD_DIGIT_W];
                ones_r     <= res_digits_s[0 +: BCD_DIGIT_W];
                ovf_r      <= res_ovf_s;
            end
        end
    end

    assign ones     = ones_r;
    assign tens     = tens_r;
    assign hundreds = hundreds_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign ovf      = ovf_r;

endmodule

// File: tb/tb_bcd_converter.sv
// Directed self-checking bench for bcd_converter (WIDTH=10); honours BCD_SATURATE_EN.
module tb_bcd_converter;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] bin;
    logic       start;
    logic [3:0] ones;
    logic [3:0] tens;
    logic [3:0] hundreds;
    logic       busy;
    logic       done;
    logic       ovf;

    int checks_cnt   = 0;
    int failures_cnt = 0;
    int neg_cyc      = 0;
    int done_at[$];

    bcd_converter #(.WIDTH(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .bin      (bin),
        .start    (start),
        .ones     (ones),
        .tens     (tens),
        .hundreds (hundreds),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    // log the falling-edge index of every done pulse
    always @(negedge clk) begin
        neg_cyc++;
        if (done) done_at.push_back(neg_cyc);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            failures_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // one conversion; poke adds ignored start pulses during SHIFT and DONE
    task automatic do_conv(input logic [9:0] v, input logic [11:0] exp_d, input logic exp_ovf,
                           input logic [11:0] prev_d, input bit poke, input string tag);
        int cycles;
        int n0;
        n0 = done_at.size();
        @(negedge clk); bin = v; start = 1'b1;
        @(negedge clk); start = 1'b0;
        check_val({tag, "_busy_on"}, 32'(busy), 32'd1);
        cycles = 0;
        while (!done && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (cycles == 3 && poke) begin start = 1'b1; bin = 10'd5; end
            if (cycles == 4) start = 1'b0;
            if (cycles == 5) check_val({tag, "_hold"}, 32'({hundreds, tens, ones}), 32'(prev_d));
        end
        check_val({tag, "_latency"}, 32'(cycles), 32'd10);
        check_val({tag, "_digits"}, 32'({hundreds, tens, ones}), 32'(exp_d));
        check_val({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        if (poke) begin start = 1'b1; bin = 10'd5; end
        @(negedge clk); start = 1'b0;
        check_val({tag, "_busy_off"}, 32'(busy), 32'd0);
        check_val({tag, "_done_pulse"}, 32'(done), 32'd0);
        if (poke) begin
            repeat (3) @(negedge clk);
            check_val({tag, "_busy_idle"}, 32'(busy), 32'd0);
            check_val({tag, "_done_count"}, 32'(done_at.size() - n0), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        int cycles;
        rst = 1'b1; start = 1'b0; bin = 10'd0;
        repeat (3) @(negedge clk);
        check_val("reset_digits", 32'({hundreds, tens, ones}), 32'h000);
        check_val("reset_flags", 32'({busy, done, ovf}), 32'd0);
        rst = 1'b0;

        do_conv(10'd0,   12'h000, 1'b0, 12'h000, 1'b0, "zero");
        do_conv(10'd255, 12'h255, 1'b0, 12'h000, 1'b0, "v255");
        do_conv(10'd999, 12'h999, 1'b0, 12'h255, 1'b1, "v999");
`ifdef BCD_SATURATE_EN
        do_conv(10'd1023, 12'h999, 1'b1, 12'h999, 1'b0, "v1023");
`else
        do_conv(10'd1023, 12'h023, 1'b0, 12'h999, 1'b0, "v1023");
`endif

        // abort on the 5th shift
        n0 = done_at.size();
        @(negedge clk); bin = 10'd123; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check_val("abort_digits", 32'({hundreds, tens, ones}), 32'h000);
        check_val("abort_flags", 32'({busy, done, ovf}), 32'd0);
        repeat (15) @(negedge clk);
        check_val("abort_no_done", 32'(done_at.size() - n0), 32'd0);
        do_conv(10'd123, 12'h123, 1'b0, 12'h000, 1'b0, "v123");

        // reset and start on the same edge: request dropped
        n0 = done_at.size();
        @(negedge clk); rst = 1'b1; start = 1'b1; bin = 10'd9;
        @(negedge clk); rst = 1'b0; start = 1'b0;
        check_val("rst_start_busy", 32'(busy), 32'd0);
        repeat (14) @(negedge clk);
        check_val("rst_start_no_done", 32'(done_at.size() - n0), 32'd0);

        // back-to-back: second start at the earliest legal edge
        n0 = done_at.size();
        @(negedge clk); bin = 10'd7; start = 1'b1;
        @(negedge clk); start = 1'b0;
        cycles = 0;
        while (!done && cycles < 40) begin @(negedge clk); cycles++; end
        check_val("b2b_first", 32'({hundreds, tens, ones}), 32'h007);
        @(negedge clk); bin = 10'd640; start = 1'b1;
        @(negedge clk); start = 1'b0;
        cycles = 0;
        while (!done && cycles < 40) begin @(negedge clk); cycles++; end
        check_val("b2b_second", 32'({hundreds, tens, ones}), 32'h640);
        @(negedge clk);
        check_val("b2b_done_count", 32'(done_at.size() - n0), 32'd2);
        if (done_at.size() - n0 == 2) begin
            check_val("b2b_spacing", 32'(done_at[n0 + 1] - done_at[n0]), 32'd12);
        end else begin
            check_val("b2b_spacing", 32'd0, 32'd12);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule
